// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types, default parameters and helpers for the UART blocks.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default configuration of the receiver
  localparam int UART_CLKS_PER_BIT_DEF = 434;
  localparam int UART_DATA_BITS_DEF    = 8;

  // Receiver frame states; PARITY is only reachable in parity-enabled builds
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_e;

  // Even-parity bit over up to 8 data bits (unused upper bits must be zero)
  function automatic logic calc_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync
// Brief    : N-flop synchronizer for an asynchronous single-bit input.
//            INIT sets the reset level of every stage.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync #(
  parameter int   N    = 2,
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [N-1:0] stages;

  // Shift the asynchronous input through N flops; stage N-1 is the safe output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= {N{INIT}};
    end else begin
      stages <= {stages[N-2:0], din};
    end
  end

  assign dout = stages[N-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Brief    : UART receiver. Oversamples the serial line, rejects start-bit
//            glitches, assembles LSB-first bytes and pushes good ones into the
//            RX FIFO with a one-cycle strobe. Flags framing, parity and
//            overrun errors as one-cycle pulses.
//            Optional macro UART_RX_PARITY_EN adds an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = UART_DATA_BITS_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 uart_rx_i,
  input  logic                 rx_fifo_full_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_data_vld_o,
  output logic                 rx_busy_o,
  output logic                 frame_err_o,
  output logic                 overrun_err_o,
  output logic                 parity_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_rx_state_e       state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift;
  logic                 line_s;
  logic                 line_prev;
  logic                 fall;

  uart_sync #(
    .N    (2),
    .INIT (1'b1)
  ) u_sync (
    .clk  (clk_i),
    .rst  (rst_i),
    .din  (uart_rx_i),
    .dout (line_s)
  );

  // History flop so a start is only recognised on a fresh 1->0 transition
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) line_prev <= 1'b1;
    else       line_prev <= line_s;
  end

  assign fall      = line_prev & ~line_s;
  assign rx_busy_o = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign parity_err_o = 1'b0;
`endif

  // Frame FSM with bit timing, data assembly and registered result pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      rx_data_o     <= '0;
      rx_data_vld_o <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o  <= 1'b0;
      par_bad       <= 1'b0;
`endif
    end else begin
      rx_data_vld_o <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            idx <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
            // A high line at mid-start means the low pulse was a glitch
            state <= line_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            idx   <= idx + IDX_W'(1);
            shift <= {line_s, shift[DATA_BITS-1:1]};
            if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_FULL) begin
            cnt     <= '0;
            par_bad <= (line_s != calc_parity(8'(shift)));
            state   <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            state <= IDLE;
            // Only one outcome per frame: framing, then parity, then overrun
            if (!line_s) begin
              frame_err_o <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              parity_err_o <= 1'b1;
`endif
            end else if (rx_fifo_full_i) begin
              overrun_err_o <= 1'b1;
            end else begin
              rx_data_o     <= shift;
              rx_data_vld_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core
// Brief    : Directed self-checking bench for uart_rx_core (16 clk/bit, 8 bits).
//            Honours UART_RX_PARITY_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

  localparam int BIT = 16;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_line = 1'b1;
  logic          fifo_full = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_vld;
  logic          rx_busy;
  logic          frame_err;
  logic          overrun_err;
  logic          parity_err;

  int checks = 0;
  int errors = 0;

  // Monitor state, written only by the monitor/cycle processes
  int       cyc = 0;
  int       vld_cnt = 0;
  int       ferr_cnt = 0;
  int       oerr_cnt = 0;
  int       perr_cnt = 0;
  int       last_vld_cyc = 0;
  logic [DB-1:0] last_data = '0;

  uart_rx_core #(
    .CLKS_PER_BIT (BIT),
    .DATA_BITS    (DB)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .uart_rx_i      (rx_line),
    .rx_fifo_full_i (fifo_full),
    .rx_data_o      (rx_data),
    .rx_data_vld_o  (rx_vld),
    .rx_busy_o      (rx_busy),
    .frame_err_o    (frame_err),
    .overrun_err_o  (overrun_err),
    .parity_err_o   (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count every cycle each output is high, so a stretched pulse is visible
  always @(negedge clk) begin
    if (rx_vld) begin
      vld_cnt      <= vld_cnt + 1;
      last_data    <= rx_data;
      last_vld_cyc <= cyc;
    end
    if (frame_err)   ferr_cnt <= ferr_cnt + 1;
    if (overrun_err) oerr_cnt <= oerr_cnt + 1;
    if (parity_err)  perr_cnt <= perr_cnt + 1;
  end

  // Drive one frame; the line is left at the stop-bit level afterwards
  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    rx_line = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx_line = d[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx_line = par_bit;
    repeat (BIT) @(negedge clk);
`else
    if (par_bit === 1'bz) rx_line = 1'b1;
`endif
    rx_line = stop_bit;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_data, rx_vld, rx_busy, frame_err, overrun_err, parity_err} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {rx_data, rx_vld, rx_busy, frame_err, overrun_err, parity_err});
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b required 0", rx_busy);
    end
  endtask

  task automatic test_single_frame();
    int v0, e0, start_cyc, lat;
    v0 = vld_cnt; e0 = ferr_cnt + oerr_cnt + perr_cnt;
    @(negedge clk);
    start_cyc = cyc;
    send_frame(8'hA5, 1'b0, 1'b1);
    checks++;
    if (vld_cnt - v0 != 1) begin
      errors++;
      $display("FAIL a5_strobes: got %0d required 1", vld_cnt - v0);
    end
    checks++;
    if (last_data !== 8'hA5) begin
      errors++;
      $display("FAIL a5_data: got %h required a5", last_data);
    end
    checks++;
    if (ferr_cnt + oerr_cnt + perr_cnt - e0 != 0) begin
      errors++;
      $display("FAIL a5_errors: got %0d required 0", ferr_cnt + oerr_cnt + perr_cnt - e0);
    end
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL a5_busy_after_stop: got %b required 0", rx_busy);
    end
    lat = last_vld_cyc - start_cyc;
`ifdef UART_RX_PARITY_EN
    lat = lat - BIT;
`endif
    checks++;
    if (lat < 155 || lat > 157) begin
      errors++;
      $display("FAIL a5_latency: got %0d required 156 +-1", lat);
    end
    repeat (BIT) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int v0, e0;
    logic [7:0] first;
    v0 = vld_cnt; e0 = ferr_cnt + oerr_cnt + perr_cnt;
    send_frame(8'h00, 1'b0, 1'b1);
    first = last_data;
    send_frame(8'hFF, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (vld_cnt - v0 != 2) begin
      errors++;
      $display("FAIL b2b_strobes: got %0d required 2", vld_cnt - v0);
    end
    checks++;
    if (first !== 8'h00 || last_data !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_data: got %h,%h required 00,ff", first, last_data);
    end
    checks++;
    if (ferr_cnt + oerr_cnt + perr_cnt - e0 != 0) begin
      errors++;
      $display("FAIL b2b_errors: got %0d required 0", ferr_cnt + oerr_cnt + perr_cnt - e0);
    end
  endtask

  task automatic test_glitch();
    int v0, e0;
    logic busy_mid;
    v0 = vld_cnt; e0 = ferr_cnt + oerr_cnt + perr_cnt;
    rx_line = 1'b0;
    repeat (4) @(negedge clk);
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    busy_mid = rx_busy;
    repeat (3 * BIT) @(negedge clk);
    checks++;
    if (busy_mid !== 1'b1) begin
      errors++;
      $display("FAIL glitch_enters_start: got busy %b required 1", busy_mid);
    end
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_back_idle: got busy %b required 0", rx_busy);
    end
    checks++;
    if (vld_cnt - v0 != 0 || ferr_cnt + oerr_cnt + perr_cnt - e0 != 0) begin
      errors++;
      $display("FAIL glitch_outputs: got strobes %0d errors %0d required 0 0",
               vld_cnt - v0, ferr_cnt + oerr_cnt + perr_cnt - e0);
    end
  endtask

  task automatic test_frame_error();
    int v0, f0, o0;
    v0 = vld_cnt; f0 = ferr_cnt; o0 = oerr_cnt + perr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (5 * BIT - BIT) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_no_retrigger: got busy %b required 0", rx_busy);
    end
    rx_line = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    checks++;
    if (ferr_cnt - f0 != 1) begin
      errors++;
      $display("FAIL ferr_pulses: got %0d required 1", ferr_cnt - f0);
    end
    checks++;
    if (vld_cnt - v0 != 0 || oerr_cnt + perr_cnt - o0 != 0) begin
      errors++;
      $display("FAIL ferr_side_effects: got strobes %0d other %0d required 0 0",
               vld_cnt - v0, oerr_cnt + perr_cnt - o0);
    end
    checks++;
    if (rx_data !== 8'hFF) begin
      errors++;
      $display("FAIL ferr_data_held: got %h required ff", rx_data);
    end
  endtask

  task automatic test_overrun();
    int v0, o0, f0;
    v0 = vld_cnt; o0 = oerr_cnt; f0 = ferr_cnt + perr_cnt;
    fifo_full = 1'b1;
    send_frame(8'h55, 1'b0, 1'b1);
    fifo_full = 1'b0;
    repeat (BIT) @(negedge clk);
    checks++;
    if (oerr_cnt - o0 != 1) begin
      errors++;
      $display("FAIL ovr_pulses: got %0d required 1", oerr_cnt - o0);
    end
    checks++;
    if (vld_cnt - v0 != 0 || ferr_cnt + perr_cnt - f0 != 0) begin
      errors++;
      $display("FAIL ovr_side_effects: got strobes %0d other %0d required 0 0",
               vld_cnt - v0, ferr_cnt + perr_cnt - f0);
    end
    checks++;
    if (rx_data !== 8'hFF) begin
      errors++;
      $display("FAIL ovr_data_held: got %h required ff", rx_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    logic [7:0] d;
    d = 8'h81;
    v0 = vld_cnt; e0 = ferr_cnt + oerr_cnt + perr_cnt;
    rx_line = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_line = d[i];
      repeat (BIT) @(negedge clk);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_abort: got busy %b data %h required 0 00", rx_busy, rx_data);
    end
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    checks++;
    if (vld_cnt - v0 != 0 || ferr_cnt + oerr_cnt + perr_cnt - e0 != 0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_quiet: got strobes %0d errors %0d busy %b required 0 0 0",
               vld_cnt - v0, ferr_cnt + oerr_cnt + perr_cnt - e0, rx_busy);
    end
    send_frame(8'h81, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (vld_cnt - v0 != 1 || last_data !== 8'h81) begin
      errors++;
      $display("FAIL rst_mid_resend: got strobes %0d data %h required 1 81",
               vld_cnt - v0, last_data);
    end
  endtask

  task automatic test_parity();
    int v0, p0;
    v0 = vld_cnt; p0 = perr_cnt;
`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity needs a 1; send 0 first
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (perr_cnt - p0 != 1 || vld_cnt - v0 != 0) begin
      errors++;
      $display("FAIL par_bad: got perr %0d strobes %0d required 1 0",
               perr_cnt - p0, vld_cnt - v0);
    end
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (perr_cnt - p0 != 1 || vld_cnt - v0 != 1 || last_data !== 8'h07) begin
      errors++;
      $display("FAIL par_good: got perr %0d strobes %0d data %h required 1 1 07",
               perr_cnt - p0, vld_cnt - v0, last_data);
    end
`else
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (perr_cnt - p0 != 0 || vld_cnt - v0 != 1 || last_data !== 8'h07) begin
      errors++;
      $display("FAIL par_disabled: got perr %0d strobes %0d data %h required 0 1 07",
               perr_cnt - p0, vld_cnt - v0, last_data);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
